// File: rtl/fifo_non2n_pkg.sv
// Shared address-window and counter-width helpers for the non-power-of-two FIFO.
// Used by the read/write pointer stages and the occupancy controller.
package fifo_non2n_pkg;

  localparam int PTR_WIDTH_DEF = 10;

  typedef logic [PTR_WIDTH_DEF-1:0] ptr_t;

  // The address window is centred in the pointer space so both stages agree on it.
  function automatic int start_addr(input int depth, input int ptr_w);
    return (1 << (ptr_w - 1)) - depth / 2;
  endfunction

  function automatic int end_addr(input int depth, input int ptr_w);
    return (1 << (ptr_w - 1)) + depth / 2 - 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rptr_handler_non2n.sv
// Wrapping read pointer over the centred address window [START_ADDR, END_ADDR].
module rptr_handler_non2n
  import fifo_non2n_pkg::*;
#(
  parameter int FIFO_DEPTH = 520,
  parameter int PTR_WIDTH  = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_adv,
  output logic [PTR_WIDTH-1:0] o_rptr
);

  localparam logic [PTR_WIDTH-1:0] START_C = PTR_WIDTH'(start_addr(FIFO_DEPTH, PTR_WIDTH));
  localparam logic [PTR_WIDTH-1:0] END_C   = PTR_WIDTH'(end_addr(FIFO_DEPTH, PTR_WIDTH));

  logic [PTR_WIDTH-1:0] r_rptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rptr <= START_C;
    end else if (i_adv) begin
      r_rptr <= (r_rptr == END_C) ? START_C : r_rptr + PTR_WIDTH'(1);
    end
  end

  assign o_rptr = r_rptr;

endmodule

// File: rtl/fifo_ctrl_non2n.sv
// Occupancy, flag, memory-strobe and error controller for the non-power-of-two FIFO.
// Sticky overflow/underflow registers exist only when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl_non2n
  import fifo_non2n_pkg::*;
#(
  parameter int FIFO_DEPTH = 520,
  parameter int PTR_WIDTH  = 10,
  parameter int CNT_WIDTH  = cnt_width(FIFO_DEPTH),
  parameter int AF_LEVEL   = FIFO_DEPTH - 8,
  parameter int AE_LEVEL   = 8
) (
  input  logic                 i_wclk,
  input  logic                 i_wrst,
  input  logic                 i_w_en,
  input  logic                 i_r_en,
  input  logic                 i_err_clr,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic [PTR_WIDTH-1:0] o_rptr,
  output logic                 o_mem_we,
  output logic                 o_mem_re,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_LEVEL);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_almost_full;
  logic                 r_almost_empty;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic                 w_mem_we;
  logic                 w_mem_re;

  // Gating by the registered flags keeps the counter inside [0, FIFO_DEPTH].
  assign w_mem_we = i_w_en & ~r_full;
  assign w_mem_re = i_r_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_mem_we, w_mem_re})
      2'b10:   w_count_nxt = r_count + CNT_WIDTH'(1);
      2'b01:   w_count_nxt = r_count - CNT_WIDTH'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_wclk) begin
    if (i_wrst) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == DEPTH_C);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= AF_C);
      r_almost_empty <= (w_count_nxt <= AE_C);
    end
  end

  rptr_handler_non2n #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rptr (
    .i_clk (i_wclk),
    .i_rst (i_wrst),
    .i_adv (w_mem_re),
    .o_rptr(o_rptr)
  );

`ifdef FIFO_CTRL_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // A new error outranks a coincident clear.
  always_ff @(posedge i_wclk) begin
    if (i_wrst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_w_en & r_full)        r_overflow  <= 1'b1;
      else if (i_err_clr)         r_overflow  <= 1'b0;
      if (i_r_en & r_empty)       r_underflow <= 1'b1;
      else if (i_err_clr)         r_underflow <= 1'b0;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  // err_clr has no function without the error registers.
  assign o_overflow  = i_err_clr & 1'b0;
  assign o_underflow = 1'b0;
`endif

  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_count        = r_count;
  assign o_mem_we       = w_mem_we;
  assign o_mem_re       = w_mem_re;

endmodule

// File: tb/tb_fifo_ctrl_non2n.sv
// Randomised and directed bench for fifo_ctrl_non2n against an occupancy/address model.
module tb_fifo_ctrl_non2n;

  localparam int DEPTH = 520;
  localparam int START = 252;
  localparam int ENDA  = 771;
  localparam int AF    = 512;
  localparam int AE    = 8;

  logic       clk = 1'b0;
  logic       wrst = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic       err_clr = 1'b0;
  logic       full, empty, almost_full, almost_empty, mem_we, mem_re, overflow, underflow;
  logic [9:0] count;
  logic [9:0] rptr;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  int m_cnt = 0;
  int m_rp  = START;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always #5 clk = ~clk;

  fifo_ctrl_non2n dut (
    .i_wclk        (clk),
    .i_wrst        (wrst),
    .i_w_en        (w_en),
    .i_r_en        (r_en),
    .i_err_clr     (err_clr),
    .o_full        (full),
    .o_empty       (empty),
    .o_almost_full (almost_full),
    .o_almost_empty(almost_empty),
    .o_count       (count),
    .o_rptr        (rptr),
    .o_mem_we      (mem_we),
    .o_mem_re      (mem_re),
    .o_overflow    (overflow),
    .o_underflow   (underflow)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs();
    bit e_ovf, e_unf;
`ifdef FIFO_CTRL_ERR_EN
    e_ovf = m_ovf;
    e_unf = m_unf;
`else
    e_ovf = 1'b0;
    e_unf = 1'b0;
`endif
    chk("count", int'(count), m_cnt);
    chk("rptr", int'(rptr), m_rp);
    chk("full", int'(full), int'(m_cnt == DEPTH));
    chk("empty", int'(empty), int'(m_cnt == 0));
    chk("almost_full", int'(almost_full), int'(m_cnt >= AF));
    chk("almost_empty", int'(almost_empty), int'(m_cnt <= AE));
    chk("overflow", int'(overflow), int'(e_ovf));
    chk("underflow", int'(underflow), int'(e_unf));
  endtask

  // Called just after a negedge: drive, check strobes, clock, update model, check registers.
  task automatic step(input bit w, input bit r, input bit c, input bit rst);
    bit acc_w, acc_r;
    w_en = w; r_en = r; err_clr = c; wrst = rst;
    #1;
    acc_w = w && (m_cnt < DEPTH);
    acc_r = r && (m_cnt > 0);
    chk("mem_we", int'(mem_we), int'(acc_w));
    chk("mem_re", int'(mem_re), int'(acc_r));
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_rp = START; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (w && m_cnt == DEPTH) m_ovf = 1'b1;
      else if (c)              m_ovf = 1'b0;
      if (r && m_cnt == 0)     m_unf = 1'b1;
      else if (c)              m_unf = 1'b0;
      m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
      if (acc_r) m_rp = (m_rp == ENDA) ? START : m_rp + 1;
    end
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    int first_af;
    int pw, pr;
    @(negedge clk);

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_rptr", int'(rptr), START);
    chk("rst_empty", int'(empty), 1);

    first_af = -1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 0);
      if (almost_full && first_af < 0) first_af = int'(count);
    end
    chk("af_rise_at", first_af, AF);
    chk("full_after_fill", int'(full), 1);
    chk("fill_rptr", int'(rptr), START);

    step(1, 1, 0, 0);
    chk("rw_full_count", int'(count), DEPTH - 1);
    chk("rw_full_rptr", int'(rptr), START + 1);

    for (int i = 0; i < 518; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("pre_wrap_rptr", int'(rptr), ENDA);
    chk("pre_wrap_count", int'(count), 5);
    step(0, 1, 0, 0);
    chk("wrap_rptr", int'(rptr), START);
    chk("wrap_count", int'(count), 4);

    while (m_cnt > 0) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 1, 1, 0);

    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 25;
      pr = (ph % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 1400; i++)
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) < 5, $urandom_range(0, 999) < 2);
    end

    step(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0);
    chk("pre_rst_count", int'(count), 300);
    step(1, 1, 0, 1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1);
  end

endmodule
